// File: rtl/dmem_copy_if.sv
// Command/status and dmem port bundle for dmem_copy_engine.
// The master side holds the controller and dmem; the slave side is the engine.
interface dmem_copy_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             busy;
  logic             done;
  logic             error;
  logic             mem_write_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_write_data;
  logic [31:0]      mem_read_data;

  modport master (
    output start, src_addr, dst_addr, len_words, mem_read_data,
    input  busy, done, error, mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    input  start, src_addr, dst_addr, len_words, mem_read_data,
    output busy, done, error, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// Word block copy engine driving the single-port dmem; two cycles per word
// (READ presents source, WRITE stores dmem's registered read data at destination).
module dmem_copy_engine #(
  parameter int MEM_BYTES = 32,
  parameter int LEN_W     = 8
) (
  input logic        clk,
  input logic        rst,
  dmem_copy_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam int SW = 32 + LEN_W + 2;

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] count;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic             we_q;
  logic [31:0]      addr_q;

  // Wide sums so a large address plus length cannot wrap back into range.
  logic [SW-1:0] src_end;
  logic [SW-1:0] dst_end;
  logic          cmd_ok;

  assign src_end = SW'(bus.src_addr) + (SW'(bus.len_words) << 2);
  assign dst_end = SW'(bus.dst_addr) + (SW'(bus.len_words) << 2);
  assign cmd_ok  = (bus.src_addr[1:0] == 2'b00) && (bus.dst_addr[1:0] == 2'b00) &&
                   (src_end <= SW'(MEM_BYTES)) && (dst_end <= SW'(MEM_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      count   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src    <= bus.src_addr;
            dst    <= bus.dst_addr;
            count  <= bus.len_words;
            busy_q <= 1'b1;
            if (!cmd_ok) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= DONE;
            end else if (bus.len_words == '0) begin
              error_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              error_q <= 1'b0;
              addr_q  <= bus.src_addr;
              state   <= READ;
            end
          end
        end
        READ: begin
          addr_q <= dst;
          we_q   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          count <= count - LEN_W'(1);
          src   <= src + 32'd4;
          dst   <= dst + 32'd4;
          we_q  <= 1'b0;
          if (count == LEN_W'(1)) begin
            addr_q <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            addr_q <= src + 32'd4;
            state  <= READ;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.mem_write_en   = we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = (state == WRITE) ? bus.mem_read_data : 32'd0;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with an 8-word registered-read dmem model.
module tb_dmem_copy_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_copy_if #(.LEN_W(8)) bus ();

  dmem_copy_engine #(.MEM_BYTES(32), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:7];
  logic [31:0] rd_q;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_idx = 3'd0;
  logic [31:0] ld_val = 32'd0;
  logic [31:0] exp_mem [0:7];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (bus.mem_write_en) mem[bus.mem_addr[4:2]] <= bus.mem_write_data;
    rd_q <= mem[bus.mem_addr[4:2]];
  end
  assign bus.mem_read_data = rd_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_word(input int idx, input logic [31:0] val);
    ld_en  = 1'b1;
    ld_idx = 3'(idx);
    ld_val = val;
    @(posedge clk); #1;
    ld_en  = 1'b0;
    exp_mem[idx] = val;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 8; i++) load_word(i, 32'h11111111 * (i + 1));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_w%0d", tag, i), mem[i], exp_mem[i]);
  endtask

  // Issues one command from an idle phase (posedge+1) and samples every cycle after E0.
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                         input int xs_cyc, input int rst_cyc,
                         output int dcyc, output int dcnt, output int wcnt);
    int cyc;
    dcyc = 0; dcnt = 0; wcnt = 0;
    bus.src_addr  = s;
    bus.dst_addr  = d;
    bus.len_words = n;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (bus.done) begin
        dcnt++;
        if (dcyc == 0) dcyc = cyc;
      end
      if (bus.mem_write_en) wcnt++;
      if (cyc == xs_cyc) begin
        bus.src_addr  = 32'd8;
        bus.dst_addr  = 32'd24;
        bus.len_words = 8'd2;
        bus.start     = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc == rst_cyc) begin
        #2 rst = 1'b1;
        #1;
        check("rst_async_we", {31'd0, bus.mem_write_en}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (cyc > 40) check("timeout", 32'd1, 32'd0);
  endtask

  int dc, dn, wn;

  initial begin
    bus.start     = 1'b0;
    bus.src_addr  = '0;
    bus.dst_addr  = '0;
    bus.len_words = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_error", {31'd0, bus.error}, 32'd0);
    check("reset_we", {31'd0, bus.mem_write_en}, 32'd0);
    check("reset_addr", bus.mem_addr, 32'd0);
    check("reset_wdata", bus.mem_write_data, 32'd0);

    load_pattern();
    run_cmd(32'd0, 32'd16, 8'd4, 0, 0, dc, dn, wn);
    check("copy4_done_cyc", dc, 9);
    check("copy4_done_cnt", dn, 1);
    check("copy4_we_cycles", wn, 4);
    check("copy4_error", {31'd0, bus.error}, 32'd0);
    for (int i = 4; i < 8; i++) exp_mem[i] = 32'h11111111 * (i - 3);
    check_mem("copy4");

    run_cmd(32'd2, 32'd16, 8'd1, 0, 0, dc, dn, wn);
    check("misalign_done_cyc", dc, 1);
    check("misalign_we_cycles", wn, 0);
    check("misalign_error", {31'd0, bus.error}, 32'd1);
    check_mem("misalign");

    run_cmd(32'd24, 32'd0, 8'd3, 0, 0, dc, dn, wn);
    check("range_done_cyc", dc, 1);
    check("range_we_cycles", wn, 0);
    check("range_error", {31'd0, bus.error}, 32'd1);

    run_cmd(32'hFFFF_FFFC, 32'd0, 8'd1, 0, 0, dc, dn, wn);
    check("wrap_done_cyc", dc, 1);
    check("wrap_we_cycles", wn, 0);
    check("wrap_error", {31'd0, bus.error}, 32'd1);
    check_mem("rejects");

    run_cmd(32'd0, 32'd16, 8'd0, 0, 0, dc, dn, wn);
    check("len0_done_cyc", dc, 1);
    check("len0_done_cnt", dn, 1);
    check("len0_we_cycles", wn, 0);
    check("len0_error_cleared", {31'd0, bus.error}, 32'd0);

    run_cmd(32'd28, 32'd0, 8'd1, 0, 0, dc, dn, wn);
    check("edge_done_cyc", dc, 3);
    check("edge_error", {31'd0, bus.error}, 32'd0);
    exp_mem[0] = 32'h44444444;
    check_mem("edge");

    load_word(0, 32'hA5A5A5A5);
    run_cmd(32'd0, 32'd4, 8'd7, 0, 0, dc, dn, wn);
    check("overlap_done_cyc", dc, 15);
    check("overlap_we_cycles", wn, 7);
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'hA5A5A5A5;
    check_mem("overlap");

    load_pattern();
    run_cmd(32'd0, 32'd16, 8'd2, 2, 0, dc, dn, wn);
    check("restart_ign_done_cnt", dn, 1);
    check("restart_ign_done_cyc", dc, 5);
    exp_mem[4] = 32'h11111111;
    exp_mem[5] = 32'h22222222;
    check_mem("restart_ign");

    load_pattern();
    run_cmd(32'd0, 32'd16, 8'd4, 0, 6, dc, dn, wn);
    check("rst_mid_done_cnt", dn, 0);
    exp_mem[4] = 32'h11111111;
    exp_mem[5] = 32'h22222222;
    check_mem("rst_mid");

    run_cmd(32'd0, 32'd16, 8'd4, 0, 0, dc, dn, wn);
    check("after_rst_done_cyc", dc, 9);
    check("after_rst_we_cycles", wn, 4);
    for (int i = 4; i < 8; i++) exp_mem[i] = 32'h11111111 * (i - 3);
    check_mem("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
